// File: rtl/mss_subsystem_sb_ccc_reset_sequencer.sv
// mss_subsystem_sb_ccc_reset_sequencer: qualifies CCC PLL lock and releases staged resets in order, counting lock losses
module mss_subsystem_sb_ccc_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY        = 16,
  parameter int NUM_STAGES         = 3,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PLL_LOCK,
  input  logic                  SW_RESET_REQ,
  output logic [NUM_STAGES-1:0] STAGE_RST,
  output logic                  READY,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_COUNT,
  output logic [1:0]            SEQ_STATE
);
  localparam int SCW = $clog2(LOCK_STABLE_CYCLES);
  localparam int DW  = STAGE_DELAY > 1 ? $clog2(STAGE_DELAY) : 1;
  typedef enum logic [1:0] {HOLD = 2'b00, STABILIZE = 2'b01, RELEASE = 2'b10, RUN = 2'b11} state_t;
  state_t                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [SCW-1:0]        stable_q, stable_d;
  logic [DW-1:0]         delay_q, delay_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d, shifted;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  lock_s, active, abort;
  // Stage resets form a shift register: each release shifts a 0 in from bit 0.
  always_comb begin
    sync_d   = {sync_q[0], PLL_LOCK};
    lock_s   = sync_q[1];
    active   = state_q != HOLD;
    abort    = active && (!lock_s || SW_RESET_REQ);
    loss_d   = loss_q + LOSS_CNT_W'(active && !lock_s && loss_q != '1);
    shifted  = rst_q << 1;
    state_d  = state_q;
    stable_d = '0;
    delay_d  = '0;
    rst_d    = rst_q;
    if (abort) begin
      state_d = HOLD;
      rst_d   = '1;
    end else begin
      case (state_q)
        HOLD: begin
          rst_d   = '1;
          state_d = lock_s ? STABILIZE : HOLD;
        end
        STABILIZE: begin
          if (stable_q == SCW'(LOCK_STABLE_CYCLES - 1)) begin
            rst_d   = shifted;
            state_d = shifted == '0 ? RUN : RELEASE;
          end else stable_d = stable_q + 1'b1;
        end
        RELEASE: begin
          if (delay_q == DW'(STAGE_DELAY - 1)) begin
            rst_d   = shifted;
            state_d = shifted == '0 ? RUN : RELEASE;
          end else delay_d = delay_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= HOLD;
      sync_q   <= '0;
      stable_q <= '0;
      delay_q  <= '0;
      rst_q    <= '1;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      delay_q  <= delay_d;
      rst_q    <= rst_d;
      loss_q   <= loss_d;
    end
  end
  assign STAGE_RST       = rst_q;
  assign READY           = state_q == RUN;
  assign LOCK_LOSS_COUNT = loss_q;
  assign SEQ_STATE       = state_q;
endmodule
